// File: rtl/lab1_idiv_pkg.sv
// Shared types and message field offsets for the lab1 iterative divider.
package lab1_idiv_pkg;

  localparam int unsigned NBITS  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned IMSG_W = 2 * NBITS + 1;
  localparam int unsigned OMSG_W = 2 * NBITS;

  // istream_msg = {is_signed, dividend a, divisor b}
  localparam int unsigned IMSG_SIGNED = 2 * NBITS;
  localparam int unsigned IMSG_A_LSB  = NBITS;
  localparam int unsigned IMSG_B_LSB  = 0;

  // ostream_msg = {quotient, remainder}
  localparam int unsigned OMSG_Q_LSB = NBITS;
  localparam int unsigned OMSG_R_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Control signal bundle produced by the FSM for each state.
  typedef struct packed {
    logic in_rdy;
    logic out_val;
    logic load;
    logic step;
    logic fix;
  } cs_t;

endpackage

// File: rtl/lab1_idiv_clz.sv
// Combinational leading-zero count; an all-zero input reports NBITS.
module lab1_idiv_clz
  import lab1_idiv_pkg::*;
(
  input  logic [NBITS-1:0] in_val,
  output logic [CNT_W-1:0] clz
);

  // Scan upward so the highest set bit is the last one to write the result.
  always_comb begin
    clz = CNT_W'(NBITS);
    for (int i = 0; i < NBITS; i++) begin
      if (in_val[i]) clz = CNT_W'(NBITS - 1 - i);
    end
  end

endmodule

// File: rtl/lab1_idiv_int_div_iter_ctrl.sv
// Divider control: IDLE -> (CALC) -> FIX -> DONE sequencing and stream handshakes.
module lab1_idiv_int_div_iter_ctrl
  import lab1_idiv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       istream_val,
  output logic       istream_rdy,
  output logic       ostream_val,
  input  logic       ostream_rdy,
  input  logic       op_zero,
  input  logic       cnt_last,
  output logic       load_en,
  output logic       step_en,
  output logic       fix_en,
  output logic [1:0] dbg_state
);

  state_e state_q, state_d;
  cs_t    cs;

  // Control table and next-state selection.
  always_comb begin
    state_d = state_q;
    cs      = '0;
    case (state_q)
      ST_IDLE: begin
        cs.in_rdy = 1'b1;
        if (istream_val) begin
          cs.load = 1'b1;
          state_d = op_zero ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        cs.step = 1'b1;
        if (cnt_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        cs.fix  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        cs.out_val = 1'b1;
        if (ostream_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is withheld while reset is asserted even though the state reads IDLE.
  assign istream_rdy = cs.in_rdy & ~reset;
  assign ostream_val = cs.out_val;
  assign load_en     = cs.load & ~reset;
  assign step_en     = cs.step;
  assign fix_en      = cs.fix;
  assign dbg_state   = state_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/lab1_idiv_int_div_iter_dpath.sv
// Divider datapath: operand/sign capture, restoring subtract step, sign fix-up.
module lab1_idiv_int_div_iter_dpath
  import lab1_idiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IMSG_W-1:0] istream_msg,
  output logic [OMSG_W-1:0] ostream_msg,
  input  logic              load_en,
  input  logic              step_en,
  input  logic              fix_en,
  output logic              op_zero,
  output logic              cnt_last
);

  logic             in_signed;
  logic [NBITS-1:0] in_a;
  logic [NBITS-1:0] in_b;
  logic [NBITS-1:0] in_abs_a;
  logic [NBITS-1:0] in_abs_b;
  logic [CNT_W-1:0] in_clz;

  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_abs_q, b_abs_d;
  logic             b_zero_q, b_zero_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [NBITS-1:0] quo_q, quo_d;
  logic [NBITS-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NBITS:0]   diff;

  assign in_signed = istream_msg[IMSG_SIGNED];
  assign in_a      = istream_msg[IMSG_A_LSB +: NBITS];
  assign in_b      = istream_msg[IMSG_B_LSB +: NBITS];

  // In unsigned mode the magnitude is the raw operand; 0x80000000 stays as-is
  // when negated, which gives the overflow case its natural result.
  assign in_abs_a = (in_signed && in_a[NBITS-1]) ? (~in_a + NBITS'(1)) : in_a;
  assign in_abs_b = (in_signed && in_b[NBITS-1]) ? (~in_b + NBITS'(1)) : in_b;

  lab1_idiv_clz u_clz (
    .in_val (in_abs_a),
    .clz    (in_clz)
  );

  // Zero operands skip the iteration entirely.
  assign op_zero  = (in_a == '0) || (in_b == '0);
  assign cnt_last = (cnt_q == CNT_W'(1));

  // Trial subtraction; bit NBITS set means the partial remainder was smaller.
  assign diff = {rem_q, quo_q[NBITS-1]} - {1'b0, b_abs_q};

  assign ostream_msg = {quo_q, rem_q};

  // Next-state datapath: load on accept, one restoring step per CALC cycle, sign fix-up.
  always_comb begin
    a_d      = a_q;
    b_abs_d  = b_abs_q;
    b_zero_d = b_zero_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    if (load_en) begin
      a_d      = in_a;
      b_abs_d  = in_abs_b;
      b_zero_d = (in_b == '0);
      neg_q_d  = in_signed && (in_a[NBITS-1] ^ in_b[NBITS-1]);
      neg_r_d  = in_signed && in_a[NBITS-1];
      // Pre-align the dividend so its leading one enters the remainder first.
      quo_d    = in_abs_a << in_clz;
      rem_d    = '0;
      cnt_d    = CNT_W'(NBITS) - in_clz;
    end else if (step_en) begin
      if (!diff[NBITS]) begin
        rem_d = diff[NBITS-1:0];
        quo_d = {quo_q[NBITS-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[NBITS-2:0], quo_q[NBITS-1]};
        quo_d = {quo_q[NBITS-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
    end else if (fix_en) begin
      if (b_zero_q) begin
        quo_d = '1;
        rem_d = a_q;
      end else begin
        quo_d = neg_q_q ? (~quo_q + NBITS'(1)) : quo_q;
        rem_d = neg_r_q ? (~rem_q + NBITS'(1)) : rem_q;
      end
    end
  end

  // Datapath registers; reset clears everything so an aborted op leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_abs_q  <= '0;
      b_zero_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_abs_q  <= b_abs_d;
      b_zero_q <= b_zero_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/lab1_idiv_int_div_iter.sv
// Iterative variable-latency integer divider behind val/rdy streams.
// Handshake: a transfer happens on a rising clk edge where val and rdy are both
// high; val must hold its message until accepted, rdy may depend on state only.
// dbg_state is the line trace of the control FSM (0 IDLE, 1 CALC, 2 FIX, 3 DONE).
module lab1_idiv_int_div_iter
  import lab1_idiv_pkg::*;
#(
  parameter int unsigned p_nbits = NBITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits:0]   istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [2*p_nbits-1:0] ostream_msg,
  output logic [1:0]           dbg_state
);

  logic load_en;
  logic step_en;
  logic fix_en;
  logic op_zero;
  logic cnt_last;

  lab1_idiv_int_div_iter_ctrl  u_ctrl  (.*);
  lab1_idiv_int_div_iter_dpath u_dpath (.*);

endmodule

// File: tb/tb_lab1_idiv_int_div_iter.sv
// Directed and randomised-stream bench for the lab1 iterative divider.
module tb_lab1_idiv_int_div_iter;

  logic        clk;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [64:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [63:0] ostream_msg;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  logic [63:0] exp_q[$];

  localparam int N_RAND = 500;

  lab1_idiv_int_div_iter dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: divide magnitudes, then apply C-style truncating signs.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    na = s && a[31];
    nb = s && b[31];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = 32'd0 - q;
    if (na)      r = 32'd0 - r;
    return {q, r};
  endfunction

  // One directed operation, with latency check and an optional stall in DONE.
  task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int elat, input int stall);
    int wt;
    int lat;
    ostream_rdy = 1'b0;
    wt = 0;
    while (!istream_rdy && wt < 50) begin
      @(posedge clk); #1;
      wt++;
    end
    check({tag, "_in_rdy"}, 64'(istream_rdy), 64'd1);
    istream_val = 1'b1;
    istream_msg = {s, a, b};
    @(posedge clk); #1;
    istream_val = 1'b0;
    istream_msg = {1'b1, 32'hDEAD_BEEF, 32'h0000_0001};
    lat = 1;
    while (!ostream_val && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_msg"}, ostream_msg, {eq, er});
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check({tag, "_stall_val"}, 64'(ostream_val), 64'd1);
      check({tag, "_stall_msg"}, ostream_msg, {eq, er});
      check({tag, "_stall_in_rdy"}, 64'(istream_rdy), 64'd0);
    end
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    ostream_rdy = 1'b0;
    check({tag, "_val_drop"}, 64'(ostream_val), 64'd0);
  endtask

  // Random stream source.
  task automatic drive_rand();
    logic        s;
    logic [31:0] a, b;
    logic        rdy_seen;
    int          wt;
    for (int i = 0; i < N_RAND; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      s = 1'($urandom_range(0, 1));
      a = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 9);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      istream_val = 1'b1;
      istream_msg = {s, a, b};
      wt = 0;
      rdy_seen = 1'b0;
      while (!rdy_seen && wt < 200) begin
        rdy_seen = istream_rdy;
        @(posedge clk); #1;
        wt++;
      end
      if (!rdy_seen) begin
        check("rand_src_timeout", 64'd0, 64'd1);
        istream_val = 1'b0;
        return;
      end
      exp_q.push_back(model(s, a, b));
      istream_val = 1'b0;
    end
  endtask

  // Random stream sink / scoreboard.
  task automatic sink_rand();
    int          got;
    int          idle;
    logic        v, r;
    logic [63:0] m;
    logic [63:0] e;
    got  = 0;
    idle = 0;
    while (got < N_RAND && idle < 300) begin
      ostream_rdy = ($urandom_range(0, 3) != 0);
      v = ostream_val;
      r = ostream_rdy;
      m = ostream_msg;
      @(posedge clk); #1;
      if (v && r) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", m, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_resp", m, e);
        end
        got++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    ostream_rdy = 1'b0;
    check("rand_count", 64'(got), 64'(N_RAND));
  endtask

  initial begin
    logic seen;
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b0;

    #1;
    check("rst_out_val", 64'(ostream_val), 64'd0);
    check("rst_out_msg", ostream_msg, 64'd0);
    check("rst_in_rdy", 64'(istream_rdy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    #11;
    reset = 1'b0;
    #1;
    check("idle_in_rdy", 64'(istream_rdy), 64'd1);
    @(posedge clk); #1;

    // unsigned basic
    do_op("u100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 9, 0);
    // signed sign combinations
    do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5, 0);
    do_op("s_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 5, 0);
    do_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 9, 0);
    do_op("s_12345_m1", 1'b1, 32'd12345, 32'hFFFF_FFFF, 32'hFFFF_CFC7, 32'h0000_0000, 16, 0);
    // divide by zero, zero dividend
    do_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0000_0005, 2, 0);
    do_op("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0000_0005, 2, 0);
    do_op("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 2, 0);
    do_op("u0_9", 1'b0, 32'd0, 32'd9, 32'h0000_0000, 32'h0000_0000, 2, 0);
    // full-width dividends
    do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 34, 0);
    do_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    do_op("u_max_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'h0000_0000, 34, 0);
    do_op("u_80_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 0);
    do_op("u7_7", 1'b0, 32'd7, 32'd7, 32'h0000_0001, 32'h0000_0000, 5, 0);
    // output back-pressure in DONE
    do_op("stall", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 9, 5);

    // back-to-back random stream against the reference model
    fork
      drive_rand();
      sink_rand();
    join
    check("rand_q_empty", 64'(exp_q.size()), 64'd0);

    // asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    istream_val = 1'b1;
    istream_msg = {1'b0, 32'hFFFF_FFFF, 32'd3};
    @(posedge clk); #1;
    istream_val = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort_in_calc", 64'(dbg_state), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out_val", 64'(ostream_val), 64'd0);
    check("abort_out_msg", ostream_msg, 64'd0);
    check("abort_in_rdy", 64'(istream_rdy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_rdy", 64'(istream_rdy), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      if (ostream_val) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_stale", 64'(seen), 64'd0);
    do_op("post_rst_10_3", 1'b0, 32'd10, 32'd3, 32'h0000_0003, 32'h0000_0001, 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
